// File: rtl/nn_label_scoreboard.sv
// Label scoreboard for the spike-detection NN: buffers {gt, ref} label pairs until the
// gated classification arrives, then accumulates a saturating confusion matrix and counters.
module nn_label_scoreboard #(
    parameter int CLASS_W = 2,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int WIN_LEN = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic [CLASS_W-1:0]   label_gt,
    input  logic [CLASS_W-1:0]   label_ref,
    input  logic                 nn_valid,
    input  logic [CLASS_W-1:0]   nn_out,
    input  logic                 clear,
    input  logic [2*CLASS_W:0]   rd_sel,
    output logic [CNT_W-1:0]     rd_data,
    output logic                 win_done,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int N         = 2 ** CLASS_W;
    localparam int NCONF     = N * N;
    localparam int NCNT      = NCONF + 2;
    localparam int AGREE_IDX = NCONF;
    localparam int TOTAL_IDX = NCONF + 1;
    localparam int IDX_W     = $clog2(NCNT);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int SEL_W     = 2 * CLASS_W + 1;
    localparam int PAIR_W    = 2 * CLASS_W;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] WIN_CNT    = CNT_W'(WIN_LEN);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [SEL_W-1:0] SEL_STATUS = SEL_W'(NCNT);

    logic [PAIR_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [CNT_W-1:0]  live_q [NCNT];
    logic [CNT_W-1:0]  live_d [NCNT];
    logic [CNT_W-1:0]  snap_q [NCNT];
    logic [CNT_W-1:0]  snap_d [NCNT];
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;
    logic              win_done_q, win_done_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              push_ok, pop_ok, fifo_empty;
    logic [PAIR_W-1:0] popped;
    logic [CLASS_W-1:0] pop_gt, pop_ref;
    logic [IDX_W-1:0]  conf_idx, rd_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // A full FIFO still accepts a push when the same cycle pops.
    always_comb begin
        fifo_empty = (count_q == '0);
        pop_ok     = nn_valid && !fifo_empty;
        push_ok    = sample_valid && ((count_q != FIFO_FULL) || pop_ok);
        popped     = fifo_mem[rd_ptr_q];
        pop_gt     = popped[PAIR_W-1:CLASS_W];
        pop_ref    = popped[CLASS_W-1:0];
        conf_idx   = IDX_W'({pop_gt, nn_out});
        rd_idx     = IDX_W'(rd_sel);
    end

    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        live_d      = live_q;
        snap_d      = snap_q;
        win_done_d  = 1'b0;
        overflow_d  = overflow_q | (sample_valid && !push_ok);
        underflow_d = underflow_q | (nn_valid && fifo_empty);
        count_d     = count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            live_d[conf_idx] = sat_inc(live_q[conf_idx]);
            if (nn_out == pop_ref) live_d[AGREE_IDX] = sat_inc(live_q[AGREE_IDX]);
            live_d[TOTAL_IDX] = sat_inc(live_q[TOTAL_IDX]);
            // The snapshot includes the sample that closes the window.
            if (WIN_LEN > 0 && live_d[TOTAL_IDX] == WIN_CNT) begin
                snap_d = live_d;
                for (int i = 0; i < NCNT; i++) live_d[i] = '0;
                win_done_d = 1'b1;
            end
        end
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            snap_d      = snap_q;
            win_done_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            for (int i = 0; i < NCNT; i++) live_d[i] = '0;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_sel < SEL_STATUS)
            rd_data_d = (WIN_LEN > 0) ? snap_q[rd_idx] : live_q[rd_idx];
        else if (rd_sel == SEL_STATUS)
            rd_data_d = CNT_W'({overflow_q, underflow_q});
    end

    // NOTE: label storage has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) fifo_mem[wr_ptr_q] <= {label_gt, label_ref};
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            win_done_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < NCNT; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            win_done_q  <= win_done_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            live_q      <= live_d;
            snap_q      <= snap_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign win_done  = win_done_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: doc/nn_label_scoreboard.md
# nn_label_scoreboard

On-chip scoreboard for the spike-detection NN classifier. It takes the ground-truth and reference-model labels that accompany each input sample, holds them until the NN produces its (gated) classification, and accumulates a saturating confusion matrix plus agreement and total counters. It sits beside the `NN` core, is driven from the same sample stream and the core's output-enable, and replaces file-based offline scoring with a register-readable result. A windowed mode snapshots and restarts statistics every `WIN_LEN` scored samples.

## Interface

Parameters:
- `CLASS_W`, 2: class label width; `N = 2**CLASS_W` classes.
- `DEPTH`, 16: label FIFO depth (power of two, ≥ NN pipeline latency + 1).
- `CNT_W`, 16: counter width.
- `WIN_LEN`, 0: 0 = free-running; >0 = snapshot-and-restart every `WIN_LEN` scored samples (must be ≤ 2**CNT_W−1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sample_valid`  in  1  a sample enters the NN this cycle; labels are captured.
- `label_gt`  in  CLASS_W  ground-truth class of that sample.
- `label_ref`  in  CLASS_W  reference (original) model class of that sample.
- `nn_valid`  in  1  NN output enable; `nn_out` is a valid classification.
- `nn_out`  in  CLASS_W  NN classification.
- `clear`  in  1  synchronous clear of live statistics, FIFO and flags.
- `rd_sel`  in  2*CLASS_W+1  readout select.
- `rd_data`  out  CNT_W  registered readout.
- `win_done`  out  1  one-cycle pulse: a window snapshot was taken.
- `overflow`  out  1  sticky: a label pair was dropped (FIFO full).
- `underflow`  out  1  sticky: `nn_valid` arrived with the FIFO empty.

## Operation

- Label FIFO, `DEPTH` entries of {gt, ref}. Push on `sample_valid`; pop on `nn_valid`.
- Simultaneous push and pop: always allowed, including when full (pop frees the slot) and when empty (the pushed pair is not popped that cycle; `underflow` is set).
- Push while full without pop: the pair is dropped and `overflow` is set. Pop while empty: no scoring, and `underflow` is set.
- Scoring on a successful pop, with popped {gt, ref}:
  - `conf[gt*N + nn_out]` +1.
  - `agree` +1 if `nn_out == ref`.
  - `total` +1.
- All counters saturate at 2**CNT_W−1 and never wrap.
- Readout map:
  - `rd_sel` 0..N²−1: `conf`.
  - N²: `agree`.
  - N²+1: `total`.
  - N²+2: {overflow, underflow} zero-extended.
  - Higher values read 0.
- With `WIN_LEN > 0`, counter entries are read from the snapshot bank. With `WIN_LEN = 0`, they are read from the live bank. Status is always live.
- Window mode: when a scoring update makes live `total == WIN_LEN`:
  - On the same edge, the snapshot bank receives all live counters including that sample.
  - The live counters are zeroed.
  - `win_done` pulses.
- `clear`:
  - Zeroes the live counters, empties the FIFO and clears both flags.
  - Overrides any push, pop or scoring in that cycle.
  - Does not modify the snapshot bank.

## Timing

- Reset (async, immediate): FIFO empty; all live and snapshot counters 0; `rd_data`, `win_done`, `overflow`, `underflow` all 0.
- Label capture: a pair pushed at edge t can be popped at edge t+1 or later.
- Score latency: `nn_valid` sampled at edge t → counters updated at edge t; visible on `rd_data` at edge t+1 when `rd_sel` is held.
- `rd_data` is a registered read of the current bank at `rd_sel`, so the data appears one cycle after the select.
- `win_done` is high for exactly the cycle after the snapshot edge.
- `overflow`/`underflow` assert on the edge of the offending event and hold until `clear` or `rst`.
- Reset asserted mid-operation discards all in-flight labels; no partial update survives.

## Test plan

- Aligned stream: `CLASS_W=2`, latency 3. Push 10 samples with gt=ref=1; after 3 cycles, 10 `nn_valid` with `nn_out=1` → `conf[5]=10`, `agree=10`, `total=10`, status 0.
- Mismatch: gt=2, ref=3, `nn_out=3`, 4 times → `conf[11]=4`, `agree=4`. Then `nn_out=0` with ref=3, 2 times → `conf[8]=2`, `agree` stays 4, `total=6`.
- FIFO boundaries: `DEPTH=4`, push 5 with no pop → `overflow=1`, 4 pops score 4. A further pop → `underflow=1`, `total=4`. Push+pop when full → no overflow.
- Saturation: `CNT_W=4`, score 20 identical samples → that counter and `total` read 15.
- Window: `WIN_LEN=8`, score 20 samples → `win_done` pulses after samples 8 and 16. Snapshot `total=8`; live total after 20 = 4.
- Clear/reset: assert `clear` concurrent with `nn_valid` → no increment, FIFO empty, flags 0, snapshot intact. Async `rst` mid-stream → all outputs 0 immediately.
